// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one execute-stage ALU between the main pipeline (requester 0) and the
// auxiliary/address unit (requester 1). Round-robin under contention, one
// operation in flight, registered ALU drive and a response register that holds
// under back-pressure.
//
// Build option: ALU_SHARE_OPCODE_CHECK_EN
//   When defined, opcodes outside the legal set are answered directly with
//   rsp_err=1 (one cycle after the handshake) and never reach the ALU.
//   When undefined, every opcode is issued and rsp_err is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; req_ready asserted for the grantee
// EXEC  | issue registers drive the ALU for exactly one cycle
// RESP  | response held on rsp_* until rsp_ready
module alu_share_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [DW-1:0]  req_a_0,
  input  logic [DW-1:0]  req_b_0,
  input  logic [OPW-1:0] req_op_0,
  input  logic [DW-1:0]  req_a_1,
  input  logic [DW-1:0]  req_b_1,
  input  logic [OPW-1:0] req_op_1,
  output logic [DW-1:0]  a_tmp_alu,
  output logic [DW-1:0]  b_tmp_alu,
  output logic [OPW-1:0] opcode_tmp_alu,
  input  logic [DW-1:0]  result_alu,
  input  logic           carry_alu,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic           last_grant;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  // Opcode register: carries the issued opcode only while in EXEC, NOP otherwise.
  logic [OPW-1:0] op_q;
  logic           id_q;

  logic           any_valid;
  logic           grant;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic [OPW-1:0] sel_op;

`ifdef ALU_SHARE_OPCODE_CHECK_EN
  function automatic logic is_legal(input logic [OPW-1:0] op);
    is_legal = (op <= OPW'(11)) ||
               (op == OPW'(24)) || (op == OPW'(26)) || (op == OPW'(27)) ||
               (op == OPW'(28)) || (op == OPW'(30));
  endfunction
`endif

  // Round-robin grant and same-cycle ready for the granted requester.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid[1];
    end
    sel_a  = grant ? req_a_1  : req_a_0;
    sel_b  = grant ? req_b_1  : req_b_0;
    sel_op = grant ? req_op_1 : req_op_0;
    req_ready = 2'b00;
    if ((state == IDLE) && any_valid) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  // Sequencer: issue registers, ALU capture and response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
`ifdef ALU_SHARE_OPCODE_CHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant;
            last_grant <= grant;
`ifdef ALU_SHARE_OPCODE_CHECK_EN
            if (!is_legal(sel_op)) begin
              // Answer directly; the ALU keeps seeing NOP.
              op_q       <= '0;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_id     <= grant;
              state      <= RESP;
            end else begin
              op_q  <= sel_op;
              state <= EXEC;
            end
`else
            op_q  <= sel_op;
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_result <= result_alu;
          rsp_carry  <= carry_alu;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
`ifdef ALU_SHARE_OPCODE_CHECK_EN
          rsp_err    <= 1'b0;
`endif
          op_q       <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ALU_SHARE_OPCODE_CHECK_EN
  assign rsp_err = 1'b0;
`endif

  assign a_tmp_alu      = a_q;
  assign b_tmp_alu      = b_q;
  assign opcode_tmp_alu = op_q;

endmodule
